recip_seq: RTL and testbench
============================

// Module: recip_seq
// PURPOSE
//  Sequential fixed-point reciprocal unit: result = floor(2^FRAC_W / (din + OFFSET)).
//  Parametrised successor to the 12-entry 256/(n+1) lookup table. Covers any input width and
//  fraction width through a bit-serial restoring divider. Adds a valid/ready handshake,
//  divide-by-zero detection and output saturation.
//  Feeds the datapath scaling stage, which holds in_valid until in_ready.
// PARAMETERS
//  IN_W    4   width of din (divisor before offset)
//  FRAC_W  8   numerator exponent; dividend = 2^FRAC_W
//  OUT_W   16  width of dout; OUT_W >= 1
//  OFFSET  1   constant added to din to form the divisor, 0 or 1
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request present; din stable while in_valid=1
//  in_ready   out  1      unit can accept (IDLE only)
//  din        in   IN_W   divisor input (unsigned)
//  out_valid  out  1      result available; held until accepted
//  out_ready  in   1      consumer accepts result
//  dout       out  OUT_W  quotient, saturated
//  div_zero   out  1      result came from a zero divisor; valid with out_valid
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, in_ready=0 while asserted, out_valid=0, dout=0, div_zero=0.
//    in_ready goes to 1 in the first cycle after release.
//  Divisor d = din + OFFSET, computed at IN_W+1 bits with no overflow.
//  Dividend N = 2^FRAC_W, held at FRAC_W+1 bits.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: in_ready=1.
//    On in_valid at an edge: latch d and clear the quotient/remainder registers.
//    If d!=0, go to CALC with bit counter = FRAC_W.
//    If d==0, go to DONE with dout=all ones and div_zero=1.
//   CALC: in_ready=0. One quotient bit per edge, MSB first (restoring division):
//    rem' = {rem, N[cnt]}; if rem' >= d then q[cnt]=1 and rem = rem'-d.
//    cnt decrements each edge. The edge that processes cnt==0 moves to DONE.
//    CALC lasts exactly FRAC_W+1 cycles.
//    The remainder register is IN_W+1 bits and the compare is IN_W+2 bits, so there is no truncation.
//   DONE: out_valid=1; dout and div_zero are stable.
//    On out_ready go to IDLE, with out_valid=0 from the next cycle.
//    Stays in DONE indefinitely under backpressure.
//  Latency: with d!=0, out_valid rises FRAC_W+2 edges after the accepting edge (9 cycles in CALC
//    for FRAC_W=8, then DONE). With d==0, out_valid rises one edge after acceptance.
//  Throughput: one result per FRAC_W+3 cycles minimum.
//    There is a 1-cycle IDLE bubble after each accept, and no input is accepted in DONE.
//  Saturation: the quotient register is FRAC_W+1 bits.
//    If the quotient is >= 2^OUT_W, dout = 2^OUT_W-1 and div_zero=0.
//    Otherwise dout is the zero-extended quotient.
//  din changes during CALC/DONE are ignored, because d is latched at acceptance.
//  out_ready while out_valid=0 has no effect. in_valid outside IDLE is not consumed.
//  Reset mid-CALC or mid-DONE: the operation is abandoned with no output.
//    The bench must see out_valid=0 immediately (async).
//  dout is a registered output. It keeps its last result in IDLE and is only cleared by reset.
// TESTING
//  T1 defaults, din=0 -> dout=0x0100 (256), div_zero=0; out_valid rises exactly 10 edges after accept.
//  T2 exhaustive din=0..15 with out_ready=1 -> dout = 256,128,85,64,51,42,36,32,28,25,23,21,19,18,17,16.
//  T3 backpressure: din=2, out_ready=0 for 20 cycles -> out_valid held at 1, dout=85 stable,
//     in_ready=0 throughout; after out_ready=1, in_ready=1 within 1 cycle.
//  T4 OFFSET=0, din=0 -> dout=0xFFFF, div_zero=1 one edge after accept.
//     Then din=1 -> dout=256, div_zero=0.
//  T5 OUT_W=8, OFFSET=1, din=0 -> quotient 256 saturates to dout=0xFF, div_zero=0.
//  T6 rst_n pulsed low mid-CALC (cycle 4 of din=5) -> out_valid=0, dout=0 at once.
//     After release a new din=5 gives 42.

Source files
------------

// File: rtl/recip_seq.sv
// Sequential fixed-point reciprocal: dout = floor(2^FRAC_W / (din + OFFSET)).
// Bit-serial restoring divider behind valid/ready handshakes, saturating output.
module recip_seq #(
    parameter int IN_W   = 4,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16,
    parameter int OFFSET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             div_zero
);

    localparam int QW = FRAC_W + 1;
    localparam int CW = $clog2(FRAC_W + 2);
    localparam int WW = (QW > OUT_W) ? QW : OUT_W;
    localparam logic [WW-1:0] OMAX = WW'({OUT_W{1'b1}});

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            alive;
    logic [IN_W:0]   d;
    logic [IN_W:0]   rem;
    logic [QW-1:0]   q;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic [IN_W:0]   d_in;
    logic [IN_W+1:0] rem_sh;
    logic [IN_W+1:0] diff;
    logic            ge;
    logic [IN_W:0]   rem_nxt;
    logic [QW-1:0]   q_nxt;
    logic            last;
    logic [WW-1:0]   q_ext;
    logic            sat;

    assign d_in = {1'b0, din} + (IN_W+1)'(OFFSET);

    // The dividend is a single set bit, so its bit at cnt is just cnt==FRAC_W
    always_comb begin
        rem_sh  = {rem, (cnt == CW'(FRAC_W))};
        ge      = rem_sh >= {1'b0, d};
        diff    = rem_sh - {1'b0, d};
        rem_nxt = ge ? diff[IN_W:0] : rem_sh[IN_W:0];
        q_nxt   = q;
        if (ge) q_nxt[cnt] = 1'b1;
        last    = (cnt == '0);
        q_ext   = WW'(q_nxt);
        sat     = q_ext > OMAX;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = alive;
                accept   = alive && in_valid;
                if (accept) state_nxt = (d_in == '0) ? DONE : CALC;
            end
            CALC: if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // alive keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            alive    <= 1'b0;
            d        <= '0;
            rem      <= '0;
            q        <= '0;
            cnt      <= '0;
            dout     <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    d   <= d_in;
                    rem <= '0;
                    q   <= '0;
                    cnt <= CW'(FRAC_W);
                    if (d_in == '0) begin
                        dout     <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        div_zero <= 1'b0;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    q   <= q_nxt;
                    cnt <= cnt - 1'b1;
                    if (last) dout <= sat ? '1 : q_ext[OUT_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_recip_seq.sv
// Directed bench for recip_seq: default, OFFSET=0 and OUT_W=8 instances.
// Stimulus changes and sampling happen on the falling clock edge.
module tb_recip_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  div_zero;
    logic [3:0]  din  [3];
    logic [15:0] dout [3];
    logic [7:0]  dout_s;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign dout[2] = {8'h00, dout_s};

    recip_seq u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .din(din[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .dout(dout[0]), .div_zero(div_zero[0])
    );

    recip_seq #(.OFFSET(0)) u_zero (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .din(din[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .dout(dout[1]), .div_zero(div_zero[1])
    );

    recip_seq #(.OUT_W(8)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .din(din[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .dout(dout_s), .div_zero(div_zero[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge with the unit idle
    task automatic run(input int u, input logic [3:0] v,
                       input logic [15:0] exp_d, input logic exp_z,
                       input int exp_lat, input string tag);
        int w;
        int lat;
        din[u] = v;
        in_valid[u] = 1'b1;
        w = 0;
        while (!in_ready[u] && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " accept"}, 32'(w < 20), 1);
        @(negedge clk);
        in_valid[u] = 1'b0;
        lat = 1;
        while (!out_valid[u] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " lat"}, lat, exp_lat);
        chk({tag, " dout"}, dout[u], exp_d);
        chk({tag, " div_zero"}, div_zero[u], exp_z);
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        chk({tag, " out_valid drop"}, out_valid[u], 0);
    endtask

    logic [15:0] exp2 [16] = '{256, 128, 85, 64, 51, 42, 36, 32,
                               28, 25, 23, 21, 19, 18, 17, 16};

    initial begin
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) din[i] = '0;
        #12;
        chk("rst in_ready", in_ready[0], 0);
        chk("rst out_valid", out_valid[0], 0);
        chk("rst dout", dout[0], 0);
        chk("rst div_zero", div_zero[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("release in_ready", in_ready[0], 0);
        @(negedge clk);
        chk("first in_ready", in_ready[0], 1);

        // T1 / T2
        for (int i = 0; i < 16; i++)
            run(0, 4'(i), exp2[i], 1'b0, 10, $sformatf("t2 din%0d", i));

        // T3: backpressure, din changes after accept are ignored
        din[0] = 4'd2;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        din[0] = 4'd9;
        repeat (9) @(negedge clk);
        chk("t3 out_valid", out_valid[0], 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3 held valid", out_valid[0], 1);
            chk("t3 held dout", dout[0], 85);
            chk("t3 held ready", in_ready[0], 0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("t3 ready back", in_ready[0], 1);
        chk("t3 valid gone", out_valid[0], 0);
        chk("t3 dout kept", dout[0], 85);

        // T4 / T5
        run(1, 4'd0, 16'hFFFF, 1'b1, 1, "t4 zero");
        run(1, 4'd1, 16'd256, 1'b0, 10, "t4 one");
        run(2, 4'd0, 16'h00FF, 1'b0, 10, "t5 sat");
        run(2, 4'd1, 16'd128, 1'b0, 10, "t5 nosat");

        // T6: abandon mid-CALC
        din[0] = 4'd5;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6 out_valid", out_valid[0], 0);
        chk("t6 dout", dout[0], 0);
        chk("t6 in_ready", in_ready[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t6 no stale out", out_valid[0], 0);
        run(0, 4'd5, 16'd42, 1'b0, 10, "t6 rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
